// File: rtl/life_manager.sv
// life_manager
// Per-frame player-health controller. Turns collision and heart-pickup
// events into the 2-bit life count shown by the heart display. After each
// non-fatal hit it opens an invulnerability window and blinks the sprite.
// When the last life is lost it raises game_over.
//
// Parameters:
//   MAX_LIFE       life count after reset or restart (fits in 2 bits)
//   INVULN_FRAMES  frames of hit immunity after a non-fatal hit (>= 1)
//   BLINK_PERIOD   frames per flash phase during immunity (>= 1)
// Ports:
//   frame_clk   frame clock, one rising edge per video frame
//   RESET       asynchronous active-low reset
//   hit         collision level; may stay high for many frames
//   heal        heart pickup, single-cycle pulse
//   start       new-game request, single-cycle pulse
//   life        current life count (registered)
//   invuln      high while hits are ignored (registered)
//   flash       sprite blink phase, only high with invuln (registered)
//   game_over   high while the player is dead (registered)
module life_manager #(
    parameter int MAX_LIFE      = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_PERIOD  = 8
) (
    input  logic       frame_clk,
    input  logic       RESET,
    input  logic       hit,
    input  logic       heal,
    input  logic       start,
    output logic [1:0] life,
    output logic       invuln,
    output logic       flash,
    output logic       game_over
);

    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam int BW = $clog2(BLINK_PERIOD + 1);
    localparam logic [1:0]    MAX_L    = MAX_LIFE[1:0];
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        ALIVE,
        INVULN,
        DEAD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    life_q, life_d;
    logic          invuln_q, invuln_d;
    logic          flash_q, flash_d;
    logic          over_q, over_d;
    logic          hit_q;
    logic [IW-1:0] inv_cnt_q, inv_cnt_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;

    logic       hit_edge;
    logic [1:0] life_healed;

    // A held collision counts once: only a rising edge of hit is an event.
    assign hit_edge = hit & ~hit_q;

    // Healing saturates at three hearts rather than wrapping to zero.
    assign life_healed = (life_q == 2'd3) ? 2'd3 : life_q + 2'd1;

    // Next-state logic. start beats a hit edge, which beats heal.
    always_comb begin
        state_d   = state_q;
        life_d    = life_q;
        invuln_d  = invuln_q;
        flash_d   = flash_q;
        over_d    = over_q;
        inv_cnt_d = inv_cnt_q;
        blk_cnt_d = blk_cnt_q;

        if (start) begin
            state_d   = ALIVE;
            life_d    = MAX_L;
            invuln_d  = 1'b0;
            flash_d   = 1'b0;
            over_d    = 1'b0;
            inv_cnt_d = '0;
            blk_cnt_d = '0;
        end else begin
            unique case (state_q)
                ALIVE: begin
                    if (hit_edge) begin
                        if (life_q >= 2'd2) begin
                            state_d   = INVULN;
                            life_d    = life_q - 2'd1;
                            inv_cnt_d = INV_LOAD;
                            blk_cnt_d = '0;
                            invuln_d  = 1'b1;
                            flash_d   = 1'b1;
                        end else begin
                            state_d = DEAD;
                            life_d  = 2'd0;
                            over_d  = 1'b1;
                        end
                    end else if (heal) begin
                        life_d = life_healed;
                    end
                end
                INVULN: begin
                    // Hit edges are ignored here, including on the final
                    // immune cycle, so a hit must land after the exit edge.
                    if (heal) begin
                        life_d = life_healed;
                    end
                    if (inv_cnt_q == '0) begin
                        state_d   = ALIVE;
                        invuln_d  = 1'b0;
                        flash_d   = 1'b0;
                        blk_cnt_d = '0;
                    end else begin
                        inv_cnt_d = inv_cnt_q - IW'(1);
                        // Toggle on the last frame of each phase so every
                        // phase lasts exactly BLINK_PERIOD frames.
                        if (blk_cnt_q == BLK_LAST) begin
                            blk_cnt_d = '0;
                            flash_d   = ~flash_q;
                        end else begin
                            blk_cnt_d = blk_cnt_q + BW'(1);
                        end
                    end
                end
                DEAD: begin
                    life_d = 2'd0;
                    over_d = 1'b1;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    // State and output registers; reset forces a fresh game immediately.
    always_ff @(posedge frame_clk or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ALIVE;
            life_q    <= MAX_L;
            invuln_q  <= 1'b0;
            flash_q   <= 1'b0;
            over_q    <= 1'b0;
            hit_q     <= 1'b0;
            inv_cnt_q <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            life_q    <= life_d;
            invuln_q  <= invuln_d;
            flash_q   <= flash_d;
            over_q    <= over_d;
            hit_q     <= hit;
            inv_cnt_q <= inv_cnt_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign life      = life_q;
    assign invuln    = invuln_q;
    assign flash     = flash_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_life_manager.sv
// tb_life_manager
// Directed bench for life_manager. Two instances share the stimulus: dutA
// uses the default timing (60-frame immunity, 8-frame blink) and dutB a
// short window (20 frames, 4-frame blink) for the flash-pattern checks.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_life_manager;

    logic       frame_clk;
    logic       RESET;
    logic       hit;
    logic       heal;
    logic       start;
    logic [1:0] lifeA, lifeB;
    logic       invA, invB;
    logic       flashA, flashB;
    logic       overA, overB;

    int total;
    int bad;

    life_manager dutA (
        .frame_clk(frame_clk),
        .RESET    (RESET),
        .hit      (hit),
        .heal     (heal),
        .start    (start),
        .life     (lifeA),
        .invuln   (invA),
        .flash    (flashA),
        .game_over(overA)
    );

    life_manager #(
        .MAX_LIFE     (3),
        .INVULN_FRAMES(20),
        .BLINK_PERIOD (4)
    ) dutB (
        .frame_clk(frame_clk),
        .RESET    (RESET),
        .hit      (hit),
        .heal     (heal),
        .start    (start),
        .life     (lifeB),
        .invuln   (invB),
        .flash    (flashB),
        .game_over(overB)
    );

    // Frame clock, period 10.
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    // Advance n rising edges and return on the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge frame_clk);
            @(negedge frame_clk);
        end
    endtask

    // Reset with idle inputs; the next rising edge is edge 1.
    task automatic doReset();
        @(negedge frame_clk);
        hit = 1'b0;
        heal = 1'b0;
        start = 1'b0;
        RESET = 1'b0;
        @(negedge frame_clk);
        RESET = 1'b1;
    endtask

    // One-frame hit pulse sampled by the next rising edge.
    task automatic pulseHit();
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge frame_clk);
        RESET = 1'b0;
        #1;
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b0 || flashA !== 1'b0 || overA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got life=%0d inv=%0b flash=%0b over=%0b want 3 0 0 0",
                     lifeA, invA, flashA, overA);
        end
        total++;
        if (lifeB !== 2'd3 || invB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs_b: got life=%0d inv=%0b want 3 0", lifeB, invB);
        end
        @(negedge frame_clk);
        RESET = 1'b1;
    endtask

    task automatic test_first_hit();
        doReset();
        tick(4);
        hit = 1'b1;
        tick(1);
        total++;
        if (lifeA !== 2'd2 || invA !== 1'b1 || overA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL first_hit: got life=%0d inv=%0b over=%0b want 2 1 0", lifeA, invA, overA);
        end
        for (int k = 6; k <= 110; k++) begin
            if (k == 105) hit = 1'b0;
            tick(1);
            total++;
            if (lifeA !== 2'd2) begin
                bad++;
                $display("[TB] FAIL held_hit_life edge %0d: got %0d want 2", k, lifeA);
            end
            total++;
            if (invA !== (k < 65)) begin
                bad++;
                $display("[TB] FAIL invuln_window edge %0d: got %0b want %0b", k, invA, (k < 65));
            end
        end
    endtask

    task automatic test_flash(input int lateBy);
        logic expFlash;
        doReset();
        tick(2);
        pulseHit();
        total++;
        if (lifeB !== 2'd2 || invB !== 1'b1 || flashB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flash_entry: got life=%0d inv=%0b flash=%0b want 2 1 1", lifeB, invB, flashB);
        end
        for (int j = 1; j <= 21; j++) begin
            hit = (j == 20 + lateBy);
            tick(1);
            if (j <= 19) begin
                expFlash = ((j / 4) % 2) == 0;
                total++;
                if (flashB !== expFlash || invB !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL flash_phase j=%0d: got flash=%0b inv=%0b want %0b 1",
                             j, flashB, invB, expFlash);
                end
            end else if (j == 20) begin
                total++;
                if (invB !== 1'b0 || flashB !== 1'b0 || lifeB !== 2'd2) begin
                    bad++;
                    $display("[TB] FAIL invuln_end: got inv=%0b flash=%0b life=%0d want 0 0 2",
                             invB, flashB, lifeB);
                end
            end else if (lateBy == 0) begin
                total++;
                if (lifeB !== 2'd2 || invB !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL hit_at_end_ignored: got life=%0d inv=%0b want 2 0", lifeB, invB);
                end
            end else begin
                total++;
                if (lifeB !== 2'd1 || invB !== 1'b1 || flashB !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL hit_after_end: got life=%0d inv=%0b flash=%0b want 1 1 1",
                             lifeB, invB, flashB);
                end
            end
        end
        hit = 1'b0;
    endtask

    task automatic test_fatal();
        doReset();
        pulseHit();
        total++;
        if (lifeA !== 2'd2) begin
            bad++;
            $display("[TB] FAIL fatal_hit1: got life=%0d want 2", lifeA);
        end
        tick(70);
        pulseHit();
        total++;
        if (lifeA !== 2'd1 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fatal_hit2: got life=%0d inv=%0b want 1 1", lifeA, invA);
        end
        tick(70);
        pulseHit();
        total++;
        if (lifeA !== 2'd0 || overA !== 1'b1 || invA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fatal_hit3: got life=%0d over=%0b inv=%0b want 0 1 0", lifeA, overA, invA);
        end
        tick(2);
        pulseHit();
        tick(1);
        heal = 1'b1;
        tick(1);
        heal = 1'b0;
        tick(1);
        total++;
        if (lifeA !== 2'd0 || overA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dead_holds: got life=%0d over=%0b want 0 1", lifeA, overA);
        end
    endtask

    task automatic test_heal_priority();
        doReset();
        heal = 1'b1;
        tick(1);
        heal = 1'b0;
        total++;
        if (lifeA !== 2'd3) begin
            bad++;
            $display("[TB] FAIL heal_saturate: got life=%0d want 3", lifeA);
        end
        pulseHit();
        tick(70);
        hit = 1'b1;
        heal = 1'b1;
        tick(1);
        hit = 1'b0;
        heal = 1'b0;
        total++;
        if (lifeA !== 2'd1 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hit_beats_heal: got life=%0d inv=%0b want 1 1", lifeA, invA);
        end
        heal = 1'b1;
        tick(1);
        total++;
        if (lifeA !== 2'd2 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL heal_in_invuln_1: got life=%0d inv=%0b want 2 1", lifeA, invA);
        end
        tick(1);
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL heal_in_invuln_2: got life=%0d inv=%0b want 3 1", lifeA, invA);
        end
        tick(1);
        heal = 1'b0;
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL heal_in_invuln_sat: got life=%0d inv=%0b want 3 1", lifeA, invA);
        end
    endtask

    task automatic test_restart();
        doReset();
        pulseHit();
        tick(70);
        pulseHit();
        tick(70);
        pulseHit();
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b0 || flashA !== 1'b0 || overA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart_dead: got life=%0d inv=%0b flash=%0b over=%0b want 3 0 0 0",
                     lifeA, invA, flashA, overA);
        end
        pulseHit();
        tick(3);
        total++;
        if (lifeA !== 2'd2 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_setup: got life=%0d inv=%0b want 2 1", lifeA, invA);
        end
        start = 1'b1;
        hit = 1'b1;
        tick(1);
        start = 1'b0;
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b0 || flashA !== 1'b0 || overA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart_invuln: got life=%0d inv=%0b flash=%0b over=%0b want 3 0 0 0",
                     lifeA, invA, flashA, overA);
        end
        tick(1);
        hit = 1'b0;
        total++;
        if (lifeA !== 2'd3) begin
            bad++;
            $display("[TB] FAIL restart_held_hit: got life=%0d want 3", lifeA);
        end
    endtask

    task automatic test_async_reset();
        doReset();
        pulseHit();
        tick(70);
        pulseHit();
        tick(2);
        total++;
        if (lifeA !== 2'd1 || invA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_setup: got life=%0d inv=%0b want 1 1", lifeA, invA);
        end
        #2;
        RESET = 1'b0;
        #1;
        total++;
        if (lifeA !== 2'd3 || invA !== 1'b0 || flashA !== 1'b0 || overA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got life=%0d inv=%0b flash=%0b over=%0b want 3 0 0 0",
                     lifeA, invA, flashA, overA);
        end
        @(negedge frame_clk);
        RESET = 1'b1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        RESET = 1'b0;
        hit = 1'b0;
        heal = 1'b0;
        start = 1'b0;
        test_reset();
        test_first_hit();
        test_flash(0);
        test_flash(1);
        test_fatal();
        test_heal_priority();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
